// File: rtl/trng_collector.sv
// rtl/trng_collector.sv - TRNG post-processing: warm-up, optional von Neumann debias (TRNG_VON_NEUMANN_EN), repetition health test, word packing
module trng_collector #(
    parameter int WORD_WIDTH    = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int REP_LIMIT     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  raw_bit,
    output logic                  trng_en,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  health_fail
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WARMUP  = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_FAIL    = 2'd3;

    localparam int WU_W  = $clog2(WARMUP_CYCLES + 1);
    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    logic [1:0]            state, state_nxt;
    logic [WU_W-1:0]       wu_cnt;
    logic [7:0]            rep_cnt, rep_next;
    logic                  prev_bit, prev_valid;
    logic [WORD_WIDTH-1:0] sr;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  collecting, fail_now, full, xfer;
    logic                  acc_valid, acc_bit;

    assign collecting = (state == S_COLLECT) && enable;

    // The first sample after COLLECT entry has no predecessor, so it starts a run of 1.
    always_comb begin
        rep_next = 8'd1;
        if (prev_valid && (raw_bit == prev_bit))
            rep_next = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;
    end

    assign fail_now = collecting && (rep_next == 8'(REP_LIMIT));

`ifdef TRNG_VON_NEUMANN_EN
    logic pair_flag, pair_bit;
    assign acc_valid = collecting && pair_flag && (raw_bit != pair_bit);
    assign acc_bit   = pair_bit;
`else
    assign acc_valid = collecting;
    assign acc_bit   = raw_bit;
`endif

    assign full = (bit_cnt == CNT_W'(WORD_WIDTH));
    assign xfer = collecting && !fail_now && !clear && full && (!rvalid || rready);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_WARMUP;
            S_WARMUP:  if (!enable) state_nxt = S_IDLE;
                       else if (wu_cnt == WU_W'(WARMUP_CYCLES - 1)) state_nxt = S_COLLECT;
            S_COLLECT: if (!enable) state_nxt = S_IDLE;
                       else if (fail_now) state_nxt = S_FAIL;
            S_FAIL:    if (clear) state_nxt = enable ? S_WARMUP : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            trng_en     <= 1'b0;
            wu_cnt      <= '0;
            rep_cnt     <= '0;
            prev_bit    <= 1'b0;
            prev_valid  <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            state   <= state_nxt;
            trng_en <= (state_nxt == S_WARMUP) || (state_nxt == S_COLLECT);

            if (state != S_WARMUP)
                wu_cnt <= '0;
            else
                wu_cnt <= wu_cnt + WU_W'(1);

            if (state_nxt != S_COLLECT) begin
                rep_cnt    <= '0;
                prev_valid <= 1'b0;
            end else if (state != S_COLLECT) begin
                rep_cnt    <= 8'd1;
                prev_valid <= 1'b0;
            end else begin
                rep_cnt    <= rep_next;
                prev_bit   <= raw_bit;
                prev_valid <= 1'b1;
            end

            if (fail_now)
                health_fail <= 1'b1;
            else if (clear)
                health_fail <= 1'b0;
        end
    end

    // Packing only advances while collecting; leaving COLLECT for any reason drops the partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (!collecting || fail_now) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (xfer) begin
            sr      <= acc_valid ? {{(WORD_WIDTH-1){1'b0}}, acc_bit} : '0;
            bit_cnt <= acc_valid ? CNT_W'(1) : '0;
        end else if (acc_valid && !full) begin
            sr      <= {sr[WORD_WIDTH-2:0], acc_bit};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

`ifdef TRNG_VON_NEUMANN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_flag <= 1'b0;
            pair_bit  <= 1'b0;
        end else if (!collecting || fail_now) begin
            pair_flag <= 1'b0;
            pair_bit  <= 1'b0;
        end else begin
            pair_flag <= !pair_flag;
            if (!pair_flag)
                pair_bit <= raw_bit;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (clear || fail_now)
                rvalid <= 1'b0;
            else if (xfer)
                rvalid <= 1'b1;
            else if (rready)
                rvalid <= 1'b0;

            if (xfer)
                rdata <= sr;
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// tb/tb_trng_collector.sv - directed self-checking bench for trng_collector
module tb_trng_collector;

    logic        clk = 1'b0;
    logic        reset, enable, clear, raw_bit, rready;
    logic        trng_en, rvalid, health_fail;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;

    trng_collector #(
        .WORD_WIDTH(32),
        .WARMUP_CYCLES(64),
        .REP_LIMIT(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .clear(clear),
        .raw_bit(raw_bit),
        .trng_en(trng_en),
        .rdata(rdata),
        .rvalid(rvalid),
        .rready(rready),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One accepted bit: a single raw sample, or a 10/01 pair when debiasing.
    task automatic feed_bit(input logic b);
`ifdef TRNG_VON_NEUMANN_EN
        raw_bit = b;
        step();
        raw_bit = ~b;
        step();
`else
        raw_bit = b;
        step();
`endif
    endtask

    task automatic feed_discard();
`ifdef TRNG_VON_NEUMANN_EN
        raw_bit = 1'b0; step(); step();
        raw_bit = 1'b1; step(); step();
`endif
    endtask

    task automatic feed_word(input logic [31:0] w, input int first, input int last, input bit disc);
        for (int i = first; i <= last; i++) begin
            feed_bit(w[31-i]);
            if (disc) feed_discard();
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; raw_bit = 1'b0; rready = 1'b0;
        repeat (3) step();
        check("reset_trng_en", {31'd0, trng_en}, 32'd0);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_health", {31'd0, health_fail}, 32'd0);

        reset = 1'b0; enable = 1'b1;
        step();
        check("enable_trng_en", {31'd0, trng_en}, 32'd1);
        repeat (5) step();
        #2 reset = 1'b1;
        #1;
        check("async_reset_trng_en", {31'd0, trng_en}, 32'd0);
        step();
        reset = 1'b0;

        step();
        check("trng_en_rise", {31'd0, trng_en}, 32'd1);
        raw_bit = 1'b1;
        repeat (64) step();
        check("warmup_not_collected", {31'd0, health_fail}, 32'd0);
        check("warmup_trng_en", {31'd0, trng_en}, 32'd1);

        feed_word(32'hAAAAAAAA, 0, 31, 1'b1);
        check("pass_through_wait", {31'd0, rvalid}, 32'd0);
        feed_word(32'h3C5A0FF1, 0, 0, 1'b0);
        check("first_word_valid", {31'd0, rvalid}, 32'd1);
        check("first_word_data", rdata, 32'hAAAAAAAA);
        feed_word(32'h3C5A0FF1, 1, 31, 1'b0);
        check("hold_valid", {31'd0, rvalid}, 32'd1);
        check("hold_stable", rdata, 32'hAAAAAAAA);
        feed_word(32'hF0000000, 0, 3, 1'b0);
        check("full_drop_stable", rdata, 32'hAAAAAAAA);

        rready = 1'b1; raw_bit = 1'b0;
        step();
        rready = 1'b0;
        check("second_word_valid", {31'd0, rvalid}, 32'd1);
        check("second_word_data", rdata, 32'h3C5A0FF1);

        raw_bit = 1'b1;
        repeat (31) step();
        check("rep_below_limit", {31'd0, health_fail}, 32'd0);
        check("rep_below_rvalid", {31'd0, rvalid}, 32'd1);
        step();
        check("rep_limit_health", {31'd0, health_fail}, 32'd1);
        check("rep_limit_rvalid", {31'd0, rvalid}, 32'd0);
        check("rep_limit_trng_en", {31'd0, trng_en}, 32'd0);

        clear = 1'b1; enable = 1'b1;
        step();
        clear = 1'b0;
        check("clear_fail_health", {31'd0, health_fail}, 32'd0);
        check("warmup_restart", {31'd0, trng_en}, 32'd1);
        repeat (64) step();
        check("rewarm_no_fail", {31'd0, health_fail}, 32'd0);

        feed_word(32'hC3C3C3C3, 0, 31, 1'b0);
        feed_word(32'h0F0F0F0F, 0, 9, 1'b0);
        check("word_a_valid", {31'd0, rvalid}, 32'd1);
        check("word_a_data", rdata, 32'hC3C3C3C3);
        enable = 1'b0;
        step();
        check("disable_trng_en", {31'd0, trng_en}, 32'd0);
        check("disable_retain_valid", {31'd0, rvalid}, 32'd1);
        check("disable_retain_data", rdata, 32'hC3C3C3C3);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("idle_handshake", {31'd0, rvalid}, 32'd0);

        enable = 1'b1;
        step();
        repeat (64) step();
        feed_word(32'h5AF09612, 0, 31, 1'b0);
        step();
        check("no_stale_valid", {31'd0, rvalid}, 32'd1);
        check("no_stale_data", rdata, 32'h5AF09612);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_buffer", {31'd0, rvalid}, 32'd0);
        check("clear_keeps_state", {31'd0, trng_en}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
